serial_query_master: RTL and testbench
======================================

Name: serial_query_master

Overview:
- Host-side partner of the serial memory-query stage.
- Accepts a parallel address over a valid/ready handshake and shifts it out LSB-first on a single serial line, framed by an enable strobe.
- Waits a fixed turnaround, then deserialises the NSize-bit reply returned serially LSB-first, and presents it as a parallel response with valid/ready.
- One query is outstanding at a time; a saturating-free wrap counter tallies completed queries for debug.

Parameters:
- NSize, 8, address and reply width in bits (serial frame payload length).
- Turn, 1, idle cycles between the last address bit and the first reply bit; legal range 0..15.
- CountW, 16, width of the completed-query counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; all state is cleared while low.
- req_valid  input  1  request address is valid.
- req_addr  input  NSize  address to query.
- req_ready  output  1  block can accept a request.
- ser_out  output  1  serial address bit to the query stage.
- ser_en  output  1  high during the NSize address-bit cycles.
- ser_in  input  1  serial reply bit from the query stage.
- resp_valid  output  1  reply word is valid.
- resp_data  output  NSize  reply word.
- resp_ready  input  1  consumer accepts the reply.
- busy  output  1  high in any state other than IDLE.
- done_count  output  CountW  number of completed (consumed) queries; wraps modulo 2^CountW.

Behaviour:
- Reset (reset low, asynchronous) drives the following: state=IDLE, req_ready=1, ser_out=0, ser_en=0, resp_valid=0, resp_data=0, busy=0, done_count=0, and the internal bit counter=0.
- States are IDLE, SEND, TURN, RECV and HOLD.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch req_addr into the shift register, clear the bit counter and go to SEND.
  - req_ready drops in the same edge.
- SEND: NSize cycles. In send cycle k (k=0..NSize-1):
  - ser_out=addr[k] and ser_en=1, both driven from registers so they are stable for the whole cycle.
  - After cycle NSize-1, go to TURN, or to RECV if Turn=0.
- TURN: Turn cycles with ser_out=0 and ser_en=0, then go to RECV.
- RECV: NSize cycles.
  - In receive cycle k, sample ser_in at the closing rising edge into resp_data[k].
  - The other resp_data bits are unchanged, and resp_data is cleared on acceptance.
  - After cycle NSize-1, go to HOLD.
- HOLD:
  - resp_valid=1, and resp_data is stable until the handshake.
  - On a rising edge with resp_ready=1: resp_valid=0, done_count+=1, go to IDLE, req_ready=1 in the next cycle.
  - No new request is accepted in HOLD.
- Latency:
  - Acceptance edge at cycle 0; resp_valid rises at cycle 2*NSize+Turn+1.
  - With defaults this is 18.
  - Minimum request-to-request spacing is 2*NSize+Turn+2 cycles, given resp_ready tied high.
- req_valid dropping after acceptance has no effect. req_addr changes after acceptance are ignored.
- resp_ready high outside HOLD is ignored.
- done_count wraps from 2^CountW-1 to 0 without a flag.
- Reset asserted mid-frame aborts immediately:
  - ser_en falls asynchronously and the partial reply is discarded.
  - After release, the block is in IDLE with req_ready=1.
- busy = (state != IDLE).

Decomposition:
- Package serial_query_pkg holds:
  - the state enum (IDLE, SEND, TURN, RECV, HOLD);
  - the default NSize constant;
  - the function frame_latency(NSize, Turn) = 2*NSize+Turn+1, which the bench uses.
- No sub-module is required. The bit counter (width clog2(max(NSize,Turn)+1)) and shift/capture registers live in the top module.

Test Plan:
- Single query, NSize=8, Turn=1, addr=0xA5:
  - ser_en high for cycles 1-8, with ser_out sequence 1,0,1,0,0,1,0,1.
  - With the bench driving ser_in bits of 0x3C LSB-first in cycles 10-17, resp_valid rises at cycle 18 with resp_data=0x3C.
- Back-pressure: resp_ready held low for 5 cycles after resp_valid.
  - resp_data stays 0x3C, req_ready stays 0, and a req_valid pulse during HOLD is not accepted.
  - On release, done_count=1.
- Back-to-back, resp_ready=1 and req_valid=1 constantly with addrs 0x01 then 0xFF:
  - the second acceptance occurs exactly 19 cycles after the first;
  - ser_out streams 1,0,0,0,0,0,0,0 then eight 1s.
- Turn=0 variant: the first reply bit is sampled in cycle 9 and resp_valid rises at cycle 17.
- Reset mid-RECV: reset low at cycle 12.
  - ser_en=0 and resp_valid=0 immediately, and resp_data=0.
  - After release, a new query (addr=0x10, reply 0x77) completes normally with done_count=1.
- Counter wrap, CountW=2: after 4 completed queries done_count=0, and after the 5th it is 1.

Source files
------------

// File: rtl/serial_query_master_pkg.sv
// Shared types and constants for the serial query master.
package serial_query_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      TURN,
      RECV,
      HOLD
   } state_e;

   localparam int NSizeDef = 8;

   // Acceptance edge to first cycle with resp_valid high.
   function automatic int frame_latency(
      input int nsize,
      input int turn
   );
      return 2 * nsize + turn + 1;
   endfunction

endpackage

// File: rtl/serial_query_master_if.sv
// Request, serial line and response signals of the query master.
interface serial_query_master_if
   import serial_query_pkg::*;
#(
   parameter int NSize = NSizeDef
);

   logic             req_valid;
   logic [NSize-1:0] req_addr;
   logic             req_ready;
   logic             ser_out;
   logic             ser_en;
   logic             ser_in;
   logic             resp_valid;
   logic [NSize-1:0] resp_data;
   logic             resp_ready;

   modport master (
      input  req_valid,
      input  req_addr,
      input  ser_in,
      input  resp_ready,
      output req_ready,
      output ser_out,
      output ser_en,
      output resp_valid,
      output resp_data
   );

   modport slave (
      output req_valid,
      output req_addr,
      output ser_in,
      output resp_ready,
      input  req_ready,
      input  ser_out,
      input  ser_en,
      input  resp_valid,
      input  resp_data
   );

endinterface

// File: rtl/serial_query_master.sv
// Shifts a query address out serially, waits the turnaround,
// then collects the serial reply and offers it on valid/ready.
module serial_query_master
   import serial_query_pkg::*;
#(
   parameter int NSize  = NSizeDef,
   parameter int Turn   = 1,
   parameter int CountW = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   serial_query_master_if.master bus,
   output logic                  busy,
   output logic [CountW-1:0]     done_count
);

   localparam int CntMax = (NSize > Turn) ? NSize : Turn;
   localparam int CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] LastBit  =
      CntW'(NSize - 1);
   localparam logic [CntW-1:0] LastTurn =
      CntW'((Turn > 0) ? Turn - 1 : 0);
   localparam logic [CntW-1:0] One = CntW'(1);

   state_e state_q, state_d;

   logic [CntW-1:0]   cnt_q;
   logic [NSize-1:0]  sh_q;
   logic [NSize-1:0]  resp_q;
   logic              ser_out_q;
   logic              ser_en_q;
   logic [CountW-1:0] done_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.req_valid) state_d = SEND;
         SEND: if (cnt_q == LastBit)
            state_d = (Turn == 0) ? RECV : TURN;
         TURN: if (cnt_q == LastTurn) state_d = RECV;
         RECV: if (cnt_q == LastBit) state_d = HOLD;
         HOLD: if (bus.resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ser_out/ser_en are registered so they hold for a full cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         sh_q      <= '0;
         resp_q    <= '0;
         ser_out_q <= 1'b0;
         ser_en_q  <= 1'b0;
         done_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (bus.req_valid) begin
               sh_q      <= bus.req_addr >> 1;
               ser_out_q <= bus.req_addr[0];
               ser_en_q  <= 1'b1;
               cnt_q     <= '0;
            end
            SEND: if (cnt_q == LastBit) begin
               ser_out_q <= 1'b0;
               ser_en_q  <= 1'b0;
               cnt_q     <= '0;
            end else begin
               ser_out_q <= sh_q[0];
               sh_q      <= sh_q >> 1;
               cnt_q     <= cnt_q + One;
            end
            TURN: begin
               cnt_q <= (cnt_q == LastTurn) ? '0 : cnt_q + One;
            end
            RECV: begin
               for (int i = 0; i < NSize; i++)
                  if (cnt_q == CntW'(i)) resp_q[i] <= bus.ser_in;
               cnt_q <= (cnt_q == LastBit) ? '0 : cnt_q + One;
            end
            HOLD: if (bus.resp_ready) begin
               resp_q <= '0;
               done_q <= done_q + CountW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.ser_out    = ser_out_q;
   assign bus.ser_en     = ser_en_q;
   assign bus.resp_valid = (state_q == HOLD);
   assign bus.resp_data  = resp_q;
   assign busy           = (state_q != IDLE);
   assign done_count     = done_q;

endmodule

// File: tb/tb_serial_query_master.sv
// Directed and random queries on Turn=1 and Turn=0 instances,
// checked against bit-level expectations from the frame rules.
module tb_serial_query_master;
  import serial_query_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  serial_query_master_if #(.NSize(8)) ifa ();
  serial_query_master_if #(.NSize(8)) ifb ();

  logic        busy_a, busy_b;
  logic [15:0] dc_a;
  logic [1:0]  dc_b;

  serial_query_master #(
    .NSize(8), .Turn(1), .CountW(16)
  ) u_a (
    .clock(clock),
    .reset(reset),
    .bus(ifa.master),
    .busy(busy_a),
    .done_count(dc_a)
  );

  serial_query_master #(
    .NSize(8), .Turn(0), .CountW(2)
  ) u_b (
    .clock(clock),
    .reset(reset),
    .bus(ifb.master),
    .busy(busy_b),
    .done_count(dc_b)
  );

  logic       req_valid [2];
  logic [7:0] req_addr  [2];
  logic       ser_in    [2];
  logic       resp_ready[2];

  logic        rq_rdy[2];
  logic        s_out [2];
  logic        s_en  [2];
  logic        r_val [2];
  logic [7:0]  r_dat [2];
  logic        bsy   [2];
  logic [15:0] dcnt  [2];

  assign ifa.req_valid  = req_valid[0];
  assign ifa.req_addr   = req_addr[0];
  assign ifa.ser_in     = ser_in[0];
  assign ifa.resp_ready = resp_ready[0];
  assign ifb.req_valid  = req_valid[1];
  assign ifb.req_addr   = req_addr[1];
  assign ifb.ser_in     = ser_in[1];
  assign ifb.resp_ready = resp_ready[1];

  assign rq_rdy[0] = ifa.req_ready;
  assign s_out[0]  = ifa.ser_out;
  assign s_en[0]   = ifa.ser_en;
  assign r_val[0]  = ifa.resp_valid;
  assign r_dat[0]  = ifa.resp_data;
  assign bsy[0]    = busy_a;
  assign dcnt[0]   = dc_a;
  assign rq_rdy[1] = ifb.req_ready;
  assign s_out[1]  = ifb.ser_out;
  assign s_en[1]   = ifb.ser_en;
  assign r_val[1]  = ifb.resp_valid;
  assign r_dat[1]  = ifb.resp_data;
  assign bsy[1]    = busy_b;
  assign dcnt[1]   = {14'b0, dc_b};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int model_cnt[2];
  int turn_of  [2];
  int acc_cyc  [2];

  function automatic void fail(input string tag);
    failures++;
    $error("FAIL %s at cycle %0d", tag, cyc);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] exp_dc(input int d);
    if (d == 0) return 16'(model_cnt[0] % 65536);
    return 16'(model_cnt[1] % 4);
  endfunction

  task automatic run_frame(
    input int         d,
    input logic [7:0] addr,
    input logic [7:0] reply
  );
    bit ok;
    ok = 1'b0;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    for (int n = 0; n < 60 && !ok; n++) begin
      ok = rq_rdy[d];
      tick();
    end
    checks++;
    if (ok !== 1'b1) fail("accept");
    acc_cyc[d]   = cyc;
    req_valid[d] = 1'b0;
    req_addr[d]  = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (s_en[d] !== 1'b1) fail("send_en");
      checks++;
      if (s_out[d] !== addr[k]) fail("send_bit");
      checks++;
      if (rq_rdy[d] !== 1'b0) fail("send_rdy");
      checks++;
      if (bsy[d] !== 1'b1) fail("send_busy");
      ser_in[d] = 1'($urandom);
      tick();
    end
    for (int t = 0; t < turn_of[d]; t++) begin
      checks++;
      if (s_en[d] !== 1'b0) fail("turn_en");
      checks++;
      if (s_out[d] !== 1'b0) fail("turn_out");
      ser_in[d] = 1'($urandom);
      tick();
    end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (s_en[d] !== 1'b0) fail("recv_en");
      checks++;
      if (r_val[d] !== 1'b0) fail("recv_valid");
      ser_in[d] = reply[j];
      tick();
    end
    ser_in[d] = 1'($urandom);
    checks++;
    if (r_val[d] !== 1'b1) fail("hold_valid");
    checks++;
    if (r_dat[d] !== reply) fail("hold_data");
  endtask

  task automatic take_resp(
    input int         d,
    input int         stall,
    input logic [7:0] reply
  );
    resp_ready[d] = 1'b0;
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (r_val[d] !== 1'b1) fail("bp_valid");
      checks++;
      if (r_dat[d] !== reply) fail("bp_data");
      checks++;
      if (rq_rdy[d] !== 1'b0) fail("bp_rdy");
      req_valid[d] = 1'($urandom);
      req_addr[d]  = 8'($urandom);
      tick();
    end
    req_valid[d] = 1'b0;
    checks++;
    if (r_val[d] !== 1'b1) fail("bp_still_valid");
    resp_ready[d] = 1'b1;
    tick();
    resp_ready[d] = 1'b0;
    model_cnt[d]++;
    checks++;
    if (r_val[d] !== 1'b0) fail("done_valid");
    checks++;
    if (rq_rdy[d] !== 1'b1) fail("done_rdy");
    checks++;
    if (bsy[d] !== 1'b0) fail("done_busy");
    checks++;
    if (r_dat[d] !== 8'h00) fail("done_data");
    checks++;
    if (dcnt[d] !== exp_dc(d)) fail("done_count");
  endtask

  task automatic check_idle(input int d);
    checks++;
    if (rq_rdy[d] !== 1'b1) fail("idle_rdy");
    checks++;
    if (s_en[d] !== 1'b0) fail("idle_en");
    checks++;
    if (s_out[d] !== 1'b0) fail("idle_out");
    checks++;
    if (r_val[d] !== 1'b0) fail("idle_valid");
    checks++;
    if (r_dat[d] !== 8'h00) fail("idle_data");
    checks++;
    if (bsy[d] !== 1'b0) fail("idle_busy");
    checks++;
    if (dcnt[d] !== exp_dc(d)) fail("idle_count");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a, r;
    int         a1;
    turn_of[0] = 1;
    turn_of[1] = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_addr[i]   = 8'h00;
      ser_in[i]     = 1'b0;
      resp_ready[i] = 1'b0;
      model_cnt[i]  = 0;
      acc_cyc[i]    = 0;
    end

    #12;
    check_idle(0);
    check_idle(1);
    @(negedge clock);
    reset = 1'b1;
    tick();

    run_frame(0, 8'hA5, 8'h3C);
    take_resp(0, 5, 8'h3C);

    resp_ready[0] = 1'b1;
    run_frame(0, 8'h01, 8'h5A);
    a1 = acc_cyc[0];
    run_frame(0, 8'hFF, 8'hC3);
    model_cnt[0]++;
    checks++;
    if (acc_cyc[0] - a1 !== frame_latency(8, 1) + 1)
      fail("b2b_gap");
    tick();
    resp_ready[0] = 1'b0;
    model_cnt[0]++;
    checks++;
    if (r_val[0] !== 1'b0) fail("b2b_valid");
    checks++;
    if (dcnt[0] !== exp_dc(0)) fail("b2b_count");

    repeat (4) begin
      a = 8'($urandom);
      r = 8'($urandom);
      run_frame(0, a, r);
      take_resp(0, int'($urandom_range(0, 3)), r);
    end

    req_valid[0] = 1'b1;
    req_addr[0]  = 8'hFF;
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    checks++;
    if (s_en[0] !== 1'b1) fail("mid_send_en");
    #2 reset = 1'b0;
    #1;
    checks++;
    if (s_en[0] !== 1'b0) fail("rst_send_en");
    checks++;
    if (bsy[0] !== 1'b0) fail("rst_send_busy");
    @(negedge clock);
    reset = 1'b1;
    tick();

    ser_in[0]    = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 8'h42;
    tick();
    req_valid[0] = 1'b0;
    repeat (11) tick();
    #2 reset = 1'b0;
    #1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    check_idle(0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_idle(0);
    run_frame(0, 8'h10, 8'h77);
    take_resp(0, 0, 8'h77);

    repeat (5) begin
      a = 8'($urandom);
      r = 8'($urandom);
      run_frame(1, a, r);
      take_resp(1, int'($urandom_range(0, 2)), r);
    end
    checks++;
    if (dcnt[1] !== 16'd1) fail("wrap_count");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
